// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   - opcode / funct constants used by the static predictor
//   - HALT_WORD, the word that parks fetch until execute redirects
//   - fetch FSM state type, predecode result and queue entry structs
//   - predecode(): static prediction for one returned instruction word
package fetch_pkg;

  localparam logic [4:0]  OP_J_PFX   = 5'b00001;   // J / JAL
  localparam logic [5:0]  OP_BC      = 6'b110010;  // BC
  localparam logic [4:0]  OP_BR_PFX  = 5'b00010;   // BEQ / BNE
  localparam logic [5:0]  OP_SPECIAL = 6'b000000;
  localparam logic [5:0]  FN_JR      = 6'b001001;  // JR / JALR
  localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;

  typedef enum logic {RUN, PARK} fetch_state_t;

  typedef struct packed {
    logic        is_jump;   // control-flow instruction of any kind
    logic        is_park;   // target unknown to fetch: wait for execute
    logic        taken;     // predicted taken
    logic [31:0] target;    // predicted next PC (pc+4 when not taken)
  } pred_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
  } entry_t;

  // Static prediction: unconditional jumps and backward conditional
  // branches are taken, forward conditional branches fall through.
  function automatic pred_t predecode(input logic [31:0] inst,
                                      input logic [31:0] pc);
    pred_t r;
    r = '{is_jump: 1'b0, is_park: 1'b0, taken: 1'b0, target: pc + 32'd4};
    if (inst == HALT_WORD) begin
      r.is_park = 1'b1;
    end else if (inst[31:27] == OP_J_PFX) begin
      r.is_jump = 1'b1;
      r.taken   = 1'b1;
      r.target  = {pc[31:28], inst[25:0], 2'b00};
    end else if (inst[31:26] == OP_BC) begin
      r.is_jump = 1'b1;
      r.taken   = 1'b1;
      r.target  = pc + {{4{inst[25]}}, inst[25:0], 2'b00};
    end else if (inst[31:27] == OP_BR_PFX) begin
      r.is_jump = 1'b1;
      if (inst[15]) begin
        r.taken  = 1'b1;
        r.target = pc + {{14{inst[15]}}, inst[15:0], 2'b00};
      end
    end else if (inst[31:26] == OP_SPECIAL && inst[5:0] == FN_JR) begin
      r.is_jump = 1'b1;
      r.is_park = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-to-decode handshake.
//   out_valid/out_ready   valid/ready handshake on the queue head
//   out_pc, out_inst      PC and instruction word of the head entry
//   out_pred_taken/target static prediction made at fetch
// master = fetch side (drives head), slave = decode side (drives ready).
interface fetch_queue_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_pred_taken;
  logic [31:0] out_pred_target;

  modport master (output out_valid, out_pc, out_inst, out_pred_taken,
                  out_pred_target, input out_ready);
  modport slave  (input out_valid, out_pc, out_inst, out_pred_taken,
                  out_pred_target, output out_ready);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO (DEPTH a power of two) with synchronous
// flush, occupancy count and a valid/ready pop port.
//   clk, rstn         clock, synchronous active-low reset
//   flush             empties the FIFO at the next edge (wins over push/pop)
//   push, push_data   write one entry (caller guarantees a free slot)
//   pop_valid/ready   head handshake; pop_data is zero while empty
//   count             current occupancy 0..DEPTH
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             pop;

  assign pop_valid = (count != '0);
  assign pop       = pop_valid && pop_ready;
  assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: prefetching fetch stage with static branch prediction and
// a decoupling instruction queue.
//   clk, rstn                 clock, synchronous active-low reset
//   inst_addr, inst_req       word address / read strobe to instruction memory
//   inst_data                 read data, valid one cycle after inst_req
//   redirect_valid/pc         PC change from execute; highest priority
//   deq (master)              queue head towards decode
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 17,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rstn,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              inst_req,
  input  logic [31:0]       inst_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  fetch_queue_if.master     deq
);
  localparam int CW = $clog2(DEPTH);

  fetch_state_t state, state_n;
  logic [31:0]  fetch_pc, fetch_pc_n;
  logic         vld_p1, squash_p1, squash_n;
  logic [31:0]  pc_p1;
  logic [CW:0]  count;
  logic [CW+1:0] used;
  logic         issue, ret, push, head_valid;
  pred_t        pd;
  entry_t       push_entry, head;

  // Stage p0: issue. Occupancy plus the read in flight must leave room,
  // so returning data always has a reserved slot.
  assign used      = {1'b0, count} + {{(CW+1){1'b0}}, vld_p1};
  assign issue     = rstn && (state == RUN) && !redirect_valid
                     && (used < (CW+2)'(DEPTH));
  assign inst_req  = issue;
  assign inst_addr = fetch_pc[ADDR_W+1:2];

  // Stage p1: memory return, predecode and enqueue.
  assign ret        = vld_p1 && !squash_p1;
  assign pd         = predecode(inst_data, pc_p1);
  assign push       = ret && !redirect_valid;
  assign push_entry = '{pc: pc_p1, inst: inst_data,
                        pred_taken: pd.taken, pred_target: pd.target};

  // A taken or parking return makes the sequential read issued in the
  // same cycle useless; it is tagged so its data is dropped next cycle.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    squash_n   = 1'b0;
    if (redirect_valid) begin
      fetch_pc_n = redirect_pc & ~32'h3;
      state_n    = RUN;
    end else begin
      if (issue) fetch_pc_n = fetch_pc + 32'd4;
      if (ret && pd.is_jump && pd.taken) begin
        fetch_pc_n = pd.target;
        squash_n   = issue;
      end
      if (ret && pd.is_park) begin
        state_n  = PARK;
        squash_n = issue;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      vld_p1    <= 1'b0;
      squash_p1 <= 1'b0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      vld_p1    <= issue;
      squash_p1 <= squash_n;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= fetch_pc;
  end

  // Stage p2: queue head towards decode.
  fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop_valid (head_valid),
    .pop_ready (deq.out_ready),
    .pop_data  (head),
    .count     (count)
  );

  assign deq.out_valid       = head_valid;
  assign deq.out_pc          = head.pc;
  assign deq.out_inst        = head.inst;
  assign deq.out_pred_taken  = head.pred_taken;
  assign deq.out_pred_target = head.pred_target;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue (RESET_PC=0x100, DEPTH=4)
// with a one-cycle-latency instruction memory model.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rstn;
  logic [16:0] inst_addr;
  logic        inst_req;
  logic [31:0] inst_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] imem [0:1023];

  always #5 clk = ~clk;

  fetch_queue_if deq_if();

  fetch_queue #(.ADDR_W(17), .DEPTH(4), .RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .inst_addr      (inst_addr),
    .inst_req       (inst_req),
    .inst_data      (inst_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq            (deq_if)
  );

  always @(posedge clk) inst_data <= inst_req ? imem[inst_addr[9:0]] : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Leaves the bench at the sample point of cycle 0 after reset release.
  task automatic start(input logic ready);
    rstn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; deq_if.out_ready = ready;
    tick(); tick();
    rstn = 1'b1; #1;
  endtask

  // Redirect asserted for one cycle t; leaves the bench at cycle t+1.
  task automatic redirect_to(input logic [31:0] pc);
    tick(); redirect_valid = 1'b1; redirect_pc = pc; #1;
    tick(); redirect_valid = 1'b0; #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; deq_if.out_ready = 1'b1;
    tick(); tick(); #1;
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", inst_req); end
    checks++; if (deq_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", deq_if.out_valid); end
    checks++; if ({deq_if.out_pc, deq_if.out_inst, deq_if.out_pred_taken, deq_if.out_pred_target} !== 97'd0) begin
      errors++; $display("FAIL reset_outs got pc %h inst %h t %b tg %h want all 0", deq_if.out_pc, deq_if.out_inst, deq_if.out_pred_taken, deq_if.out_pred_target); end
    checks++; if (inst_addr !== 17'h40) begin errors++; $display("FAIL reset_addr got %h want 40", inst_addr); end
  endtask

  task automatic test_straight();
    start(1'b1);
    checks++; if ({inst_req, inst_addr} !== {1'b1, 17'h40}) begin errors++; $display("FAIL str_c0_req got %b/%h want 1/40", inst_req, inst_addr); end
    checks++; if (deq_if.out_valid !== 1'b0) begin errors++; $display("FAIL str_c0_valid got %b want 0", deq_if.out_valid); end
    tick();
    checks++; if ({inst_req, inst_addr, deq_if.out_valid} !== {1'b1, 17'h41, 1'b0}) begin
      errors++; $display("FAIL str_c1 got req %b addr %h valid %b want 1 41 0", inst_req, inst_addr, deq_if.out_valid); end
    tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc, deq_if.out_pred_taken, deq_if.out_pred_target} !== {1'b1, 32'h100, 1'b0, 32'h104}) begin
      errors++; $display("FAIL str_c2 got v %b pc %h t %b tg %h want 1 100 0 104", deq_if.out_valid, deq_if.out_pc, deq_if.out_pred_taken, deq_if.out_pred_target); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if ({deq_if.out_valid, deq_if.out_pc, inst_req} !== {1'b1, 32'h100 + 32'(4*k), 1'b1}) begin
        errors++; $display("FAIL str_stream%0d got v %b pc %h req %b want 1 %h 1", k, deq_if.out_valid, deq_if.out_pc, inst_req, 32'h100 + 32'(4*k)); end
    end
  endtask

  task automatic test_jump();
    imem[10'h40] = 32'h0800_0040;   // J to 0x100 (self loop)
    start(1'b1);
    tick(); tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc, deq_if.out_pred_taken, deq_if.out_pred_target} !== {1'b1, 32'h100, 1'b1, 32'h100}) begin
      errors++; $display("FAIL jmp_head got v %b pc %h t %b tg %h want 1 100 1 100", deq_if.out_valid, deq_if.out_pc, deq_if.out_pred_taken, deq_if.out_pred_target); end
    checks++; if ({inst_req, inst_addr} !== {1'b1, 17'h40}) begin errors++; $display("FAIL jmp_refetch got %b/%h want 1/40", inst_req, inst_addr); end
    tick();
    checks++; if (deq_if.out_valid !== 1'b0) begin errors++; $display("FAIL jmp_bubble got %b want 0", deq_if.out_valid); end
    tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL jmp_again got v %b pc %h want 1 100", deq_if.out_valid, deq_if.out_pc); end
  endtask

  task automatic test_redirect_vs_branch();
    imem[10'h80] = 32'h0;
    start(1'b1);
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;   // J returns in this cycle
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL rvb_req_in_redirect got %b want 0", inst_req); end
    tick(); redirect_valid = 1'b0; #1;
    checks++; if ({inst_req, inst_addr, deq_if.out_valid} !== {1'b1, 17'h80, 1'b0}) begin
      errors++; $display("FAIL rvb_t1 got req %b addr %h v %b want 1 80 0", inst_req, inst_addr, deq_if.out_valid); end
    tick();
    checks++; if (deq_if.out_valid !== 1'b0) begin errors++; $display("FAIL rvb_t2_valid got %b want 0", deq_if.out_valid); end
    tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc, deq_if.out_pred_taken} !== {1'b1, 32'h200, 1'b0}) begin
      errors++; $display("FAIL rvb_t3 got v %b pc %h t %b want 1 200 0", deq_if.out_valid, deq_if.out_pc, deq_if.out_pred_taken); end
    imem[10'h40] = 32'h0;
  endtask

  task automatic test_branch();
    imem[10'h80] = 32'h1000_FFFF;   // backward BEQ: 0x200 - 4
    redirect_to(32'h200);
    checks++; if ({inst_req, inst_addr} !== {1'b1, 17'h80}) begin errors++; $display("FAIL beq_req got %b/%h want 1/80", inst_req, inst_addr); end
    tick(); tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc, deq_if.out_pred_taken, deq_if.out_pred_target} !== {1'b1, 32'h200, 1'b1, 32'h1FC}) begin
      errors++; $display("FAIL beq_back got v %b pc %h t %b tg %h want 1 200 1 1fc", deq_if.out_valid, deq_if.out_pc, deq_if.out_pred_taken, deq_if.out_pred_target); end
    checks++; if (inst_addr !== 17'h7F) begin errors++; $display("FAIL beq_target_addr got %h want 7f", inst_addr); end
    tick();
    checks++; if (deq_if.out_valid !== 1'b0) begin errors++; $display("FAIL beq_bubble got %b want 0", deq_if.out_valid); end
    tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc} !== {1'b1, 32'h1FC}) begin
      errors++; $display("FAIL beq_next got v %b pc %h want 1 1fc", deq_if.out_valid, deq_if.out_pc); end
    imem[10'h80] = 32'h1000_0002;   // forward BEQ: not taken
    redirect_to(32'h200);
    tick(); tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc, deq_if.out_pred_taken, deq_if.out_pred_target} !== {1'b1, 32'h200, 1'b0, 32'h204}) begin
      errors++; $display("FAIL beq_fwd got v %b pc %h t %b tg %h want 1 200 0 204", deq_if.out_valid, deq_if.out_pc, deq_if.out_pred_taken, deq_if.out_pred_target); end
    tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc} !== {1'b1, 32'h204}) begin
      errors++; $display("FAIL beq_fwd_next got v %b pc %h want 1 204", deq_if.out_valid, deq_if.out_pc); end
    imem[10'h80] = 32'hCBFF_FFFC;   // BC with offset -4 words
    redirect_to(32'h200);
    tick(); tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc, deq_if.out_pred_taken, deq_if.out_pred_target} !== {1'b1, 32'h200, 1'b1, 32'h1F0}) begin
      errors++; $display("FAIL bc_head got v %b pc %h t %b tg %h want 1 200 1 1f0", deq_if.out_valid, deq_if.out_pc, deq_if.out_pred_taken, deq_if.out_pred_target); end
    tick(); tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc} !== {1'b1, 32'h1F0}) begin
      errors++; $display("FAIL bc_next got v %b pc %h want 1 1f0", deq_if.out_valid, deq_if.out_pc); end
    imem[10'h80] = 32'h0;
  endtask

  task automatic test_full();
    start(1'b0);
    for (int k = 0; k < 4; k++) tick();
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL full_stop_req got %b want 0", inst_req); end
    for (int k = 0; k < 5; k++) tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc, inst_req} !== {1'b1, 32'h100, 1'b0}) begin
      errors++; $display("FAIL full_hold got v %b pc %h req %b want 1 100 0", deq_if.out_valid, deq_if.out_pc, inst_req); end
    tick(); deq_if.out_ready = 1'b1; #1;
    checks++; if ({deq_if.out_valid, deq_if.out_pc, inst_req} !== {1'b1, 32'h100, 1'b0}) begin
      errors++; $display("FAIL full_release got v %b pc %h req %b want 1 100 0", deq_if.out_valid, deq_if.out_pc, inst_req); end
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++; if ({deq_if.out_valid, deq_if.out_pc} !== {1'b1, 32'h100 + 32'(4*k)}) begin
        errors++; $display("FAIL full_drain%0d got v %b pc %h want 1 %h", k, deq_if.out_valid, deq_if.out_pc, 32'h100 + 32'(4*k)); end
    end
  endtask

  task automatic test_redirect_full();
    start(1'b0);
    for (int k = 0; k < 4; k++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h80; #1;   // 3 queued + 1 in flight
    tick(); redirect_valid = 1'b0; #1;
    checks++; if (deq_if.out_valid !== 1'b0) begin errors++; $display("FAIL rfull_flush got %b want 0", deq_if.out_valid); end
    checks++; if ({inst_req, inst_addr} !== {1'b1, 17'h20}) begin errors++; $display("FAIL rfull_req got %b/%h want 1/20", inst_req, inst_addr); end
    tick(); tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc} !== {1'b1, 32'h80}) begin
      errors++; $display("FAIL rfull_first got v %b pc %h want 1 80", deq_if.out_valid, deq_if.out_pc); end
    tick(); deq_if.out_ready = 1'b1; #1;
    tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc} !== {1'b1, 32'h84}) begin
      errors++; $display("FAIL rfull_second got v %b pc %h want 1 84", deq_if.out_valid, deq_if.out_pc); end
  endtask

  task automatic test_park();
    imem[10'h0C0] = 32'h0000_0009;   // JR at 0x300
    imem[10'h100] = 32'h0;
    imem[10'h101] = 32'hFFFF_FFFF;   // halt at 0x404
    redirect_to(32'h300);
    checks++; if ({inst_req, inst_addr} !== {1'b1, 17'hC0}) begin errors++; $display("FAIL jr_req got %b/%h want 1/c0", inst_req, inst_addr); end
    tick(); tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc, deq_if.out_inst, inst_req} !== {1'b1, 32'h300, 32'h9, 1'b0}) begin
      errors++; $display("FAIL jr_head got v %b pc %h inst %h req %b want 1 300 9 0", deq_if.out_valid, deq_if.out_pc, deq_if.out_inst, inst_req); end
    tick();
    checks++; if ({deq_if.out_valid, inst_req} !== 2'b00) begin
      errors++; $display("FAIL jr_parked got v %b req %b want 0 0", deq_if.out_valid, inst_req); end
    tick(); tick(); tick();
    checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL jr_still_parked got %b want 0", inst_req); end
    redirect_to(32'h400);
    checks++; if ({inst_req, inst_addr} !== {1'b1, 17'h100}) begin errors++; $display("FAIL resume_req got %b/%h want 1/100", inst_req, inst_addr); end
    tick(); tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc} !== {1'b1, 32'h400}) begin
      errors++; $display("FAIL resume_head got v %b pc %h want 1 400", deq_if.out_valid, deq_if.out_pc); end
    tick();
    checks++; if ({deq_if.out_valid, deq_if.out_pc, deq_if.out_inst, deq_if.out_pred_taken, deq_if.out_pred_target, inst_req}
                  !== {1'b1, 32'h404, 32'hFFFF_FFFF, 1'b0, 32'h408, 1'b0}) begin
      errors++; $display("FAIL halt_head got v %b pc %h inst %h t %b tg %h req %b want 1 404 ffffffff 0 408 0",
                         deq_if.out_valid, deq_if.out_pc, deq_if.out_inst, deq_if.out_pred_taken, deq_if.out_pred_target, inst_req); end
    tick();
    checks++; if ({deq_if.out_valid, inst_req} !== 2'b00) begin
      errors++; $display("FAIL halt_parked got v %b req %b want 0 0", deq_if.out_valid, inst_req); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
    test_reset();
    test_straight();
    test_jump();
    test_redirect_vs_branch();
    test_branch();
    test_full();
    test_redirect_full();
    test_park();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
